insfetch: RTL and testbench
===========================

INSFETCH -- requirements
Module: insfetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, start PC of thread 0 after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ins_addr  output  32  instruction-memory read address; combinational from the selected thread's PC.
REQ-005 ins_rdata  input  32  instruction-memory read data, valid in the same cycle as ins_addr.
REQ-006 stall_fe  input  1  hold the fetch/decode register and all PC increments.
REQ-007 jmp_en_exe, jmp_trd_exe[2:0], jmp_pc_exe[31:0]  input  redirect of one thread's PC.
REQ-008 spawn_en_exe, spawn_trd_exe[2:0], spawn_pc_exe[31:0]  input  activate a reserved thread at a start PC.
REQ-009 kill_en_exe, kill_trd_exe[2:0]  input  deactivate one thread.
REQ-010 init_trd_dec  input  1  decode has seen a spawn instruction; reserve new_trd_id.
REQ-011 ins_dec[31:0], pc_dec[31:0], trd_dec[2:0], valid_dec  output  fetch/decode pipeline register.
REQ-012 flushID  output  1  combinational; squash the instruction currently in decode.
REQ-013 new_trd_id[2:0], no_free_trd  output  combinational; lowest free thread ID, and an all-busy flag.

Function
REQ-014 Per-thread state: pc[8] (32b), active[8], reserved[8].
REQ-015 Eligible thread: active, and not the target of jmp_en_exe or kill_en_exe in the current cycle.
REQ-016 Round-robin selection: choose the first eligible thread strictly after last_trd (modulo 8), searching upward; last_trd updates only on an issue.
REQ-017 Issue occurs when stall_fe=0 and at least one thread is eligible.
- Register update: ins_dec<=ins_rdata, pc_dec<=pc[sel], trd_dec<=sel, valid_dec<=1.
- PC update: pc[sel]<=pc[sel]+4, wrapping modulo 2^32.
REQ-018 If stall_fe=0 and no thread is eligible, load a bubble: ins_dec<=0 (NOP), valid_dec<=0; pc_dec and trd_dec hold.
REQ-019 When stall_fe=1, the decode register and last_trd hold. Redirect, spawn, kill and reserve still update the per-thread state.
REQ-020 Redirect: pc[jmp_trd_exe]<=jmp_pc_exe; it overrides the increment.
REQ-021 flushID=1 when valid_dec=1 and either condition holds:
- jmp_en_exe=1 and trd_dec==jmp_trd_exe; or
- kill_en_exe=1 and trd_dec==kill_trd_exe.
REQ-022 On a flush with stall_fe=0, the register loads per REQ-017/018. On a flush with stall_fe=1, valid_dec<=0 and ins_dec<=0.
REQ-023 new_trd_id is the lowest index with active=0 and reserved=0. If none exists: new_trd_id=0 and no_free_trd=1.
REQ-024 init_trd_dec=1 with no_free_trd=0 sets reserved[new_trd_id]. With no_free_trd=1 the request is ignored.
REQ-025 Spawn: if active[spawn_trd_exe]=0, set active and pc to spawn_pc_exe and clear reserved. A spawn onto an already active thread is ignored.
REQ-026 Kill clears both active and reserved for the thread. Kill has priority over redirect and spawn when they target the same thread in the same cycle.
REQ-027 Events on different threads in the same cycle all take effect.

Reset
REQ-028 On rst_n=0, asynchronously:
- thread state: active=8'b0000_0001, reserved=0, pc[0]=RESET_PC, other PCs=0, last_trd=7;
- register outputs: ins_dec=0, pc_dec=0, trd_dec=0, valid_dec=0.
REQ-029 Reset asserted mid-operation discards all thread state. The first issue after release is thread 0 at RESET_PC.

Structure
REQ-030 NUM_TRD=8, TRD_W=3, NOP=32'h0 and the PC increment of 4 belong in the shared header package.
REQ-031 The round-robin pick (eligible mask and last_trd in; sel and found out) is the sub-module trd_sched.

Verification
REQ-032 Reset, then idle 3 cycles -> ins_addr = 0, 4, 8; trd_dec=0 each cycle; valid_dec=1 after the first edge.
REQ-033 Spawn thread 1 at 0x100 while thread 0 runs -> issue order interleaves T0, T1, T0, T1; T1 PCs are 0x100, 0x104.
REQ-034 jmp_en_exe for thread 1 to 0x200 while trd_dec=1 in decode -> flushID=1 that cycle; the next T1 issue has pc_dec=0x200.
REQ-035 init_trd_dec pulsed 7 times with no spawn -> new_trd_id steps 1..7; then no_free_trd=1 and new_trd_id=0.
REQ-036 Kill and redirect of thread 0 in the same cycle, no other active thread -> thread 0 is inactive and valid_dec=0 bubbles follow.
REQ-037 stall_fe held for 2 cycles -> decode register and PCs are unchanged; a redirect applied during the stall takes effect on the first issue after it.

Source files
------------

// File: rtl/insfetch_pkg.sv
// Shared constants and types for the multi-threaded instruction fetch stage.
package insfetch_pkg;

    localparam int          NUM_TRD = 8;
    localparam int          TRD_W   = 3;
    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] PC_INC  = 32'h0000_0004;

    typedef logic [TRD_W-1:0]   trd_id_t;
    typedef logic [NUM_TRD-1:0] trd_mask_t;

    function automatic trd_mask_t trd_onehot(input trd_id_t id);
        trd_onehot = {{(NUM_TRD-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/insfetch_trd_sched.sv
// Round-robin thread picker: first eligible thread strictly after last_trd, searching upward.
module trd_sched
    import insfetch_pkg::*;
(
    input  trd_mask_t eligible,
    input  trd_id_t   last_trd,
    output trd_id_t   sel,
    output logic      found
);

    // Walk candidates from farthest to nearest so the nearest eligible one wins.
    always_comb begin
        trd_id_t idx;
        sel   = {TRD_W{1'b0}};
        found = 1'b0;
        idx   = {TRD_W{1'b0}};
        for (int k = NUM_TRD; k >= 1; k--) begin
            idx = last_trd + trd_id_t'(k);
            if (eligible[idx]) begin
                sel   = idx;
                found = 1'b1;
            end else begin
                sel   = sel;
                found = found;
            end
        end
    end

endmodule

// File: rtl/insfetch.sv
// Fetch stage for an 8-thread barrel core: per-thread PCs, round-robin issue,
// thread spawn/kill/redirect and thread-ID reservation for decode.
module insfetch
    import insfetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] ins_addr,
    input  logic [31:0] ins_rdata,
    input  logic        stall_fe,
    input  logic        jmp_en_exe,
    input  logic [2:0]  jmp_trd_exe,
    input  logic [31:0] jmp_pc_exe,
    input  logic        spawn_en_exe,
    input  logic [2:0]  spawn_trd_exe,
    input  logic [31:0] spawn_pc_exe,
    input  logic        kill_en_exe,
    input  logic [2:0]  kill_trd_exe,
    input  logic        init_trd_dec,
    output logic [31:0] ins_dec,
    output logic [31:0] pc_dec,
    output logic [2:0]  trd_dec,
    output logic        valid_dec,
    output logic        flushID,
    output logic [2:0]  new_trd_id,
    output logic        no_free_trd
);

    logic [31:0] pc_r [NUM_TRD];
    trd_mask_t   active_r;
    trd_mask_t   reserved_r;
    trd_id_t     last_trd_r;

    trd_mask_t   jmp_oh_s;
    trd_mask_t   kill_oh_s;
    trd_mask_t   spawn_oh_s;
    trd_mask_t   reserve_oh_s;
    trd_mask_t   eligible_s;
    trd_id_t     sel_s;
    logic        found_s;
    logic        issue_s;

    // Per-event one-hot target masks and the eligibility mask for this cycle.
    always_comb begin
        jmp_oh_s     = {NUM_TRD{1'b0}};
        kill_oh_s    = {NUM_TRD{1'b0}};
        spawn_oh_s   = {NUM_TRD{1'b0}};
        reserve_oh_s = {NUM_TRD{1'b0}};
        if (jmp_en_exe) begin
            jmp_oh_s = trd_onehot(jmp_trd_exe);
        end else begin
            jmp_oh_s = {NUM_TRD{1'b0}};
        end
        if (kill_en_exe) begin
            kill_oh_s = trd_onehot(kill_trd_exe);
        end else begin
            kill_oh_s = {NUM_TRD{1'b0}};
        end
        if (spawn_en_exe) begin
            spawn_oh_s = trd_onehot(spawn_trd_exe);
        end else begin
            spawn_oh_s = {NUM_TRD{1'b0}};
        end
        if (init_trd_dec && !no_free_trd) begin
            reserve_oh_s = trd_onehot(new_trd_id);
        end else begin
            reserve_oh_s = {NUM_TRD{1'b0}};
        end
        eligible_s = active_r & ~jmp_oh_s & ~kill_oh_s;
    end

    trd_sched u_trd_sched (
        .eligible (eligible_s),
        .last_trd (last_trd_r),
        .sel      (sel_s),
        .found    (found_s)
    );

    assign issue_s  = !stall_fe && found_s;
    assign ins_addr = pc_r[sel_s];
    assign flushID  = valid_dec &&
                      ((jmp_en_exe  && (trd_dec == jmp_trd_exe)) ||
                       (kill_en_exe && (trd_dec == kill_trd_exe)));

    // Lowest thread that is neither running nor already promised to a spawn.
    always_comb begin
        new_trd_id  = {TRD_W{1'b0}};
        no_free_trd = 1'b1;
        for (int i = NUM_TRD - 1; i >= 0; i--) begin
            if (!active_r[i] && !reserved_r[i]) begin
                new_trd_id  = trd_id_t'(i);
                no_free_trd = 1'b0;
            end else begin
                new_trd_id  = new_trd_id;
                no_free_trd = no_free_trd;
            end
        end
    end

    // Thread state: kill beats spawn beats redirect beats the issue increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TRD; i++) begin
                pc_r[i] <= (i == 0) ? RESET_PC : 32'h0000_0000;
            end
            active_r   <= {{(NUM_TRD-1){1'b0}}, 1'b1};
            reserved_r <= {NUM_TRD{1'b0}};
        end else begin
            for (int i = 0; i < NUM_TRD; i++) begin
                if (kill_oh_s[i]) begin
                    active_r[i]   <= 1'b0;
                    reserved_r[i] <= 1'b0;
                end else if (spawn_oh_s[i] && !active_r[i]) begin
                    active_r[i]   <= 1'b1;
                    reserved_r[i] <= 1'b0;
                    pc_r[i]       <= spawn_pc_exe;
                end else begin
                    if (reserve_oh_s[i]) begin
                        reserved_r[i] <= 1'b1;
                    end
                    if (jmp_oh_s[i]) begin
                        pc_r[i] <= jmp_pc_exe;
                    end else if (issue_s && (sel_s == trd_id_t'(i))) begin
                        pc_r[i] <= pc_r[i] + PC_INC;
                    end
                end
            end
        end
    end

    // Round-robin pointer advances only when an instruction is actually issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_trd_r <= trd_id_t'(NUM_TRD - 1);
        end else if (issue_s) begin
            last_trd_r <= sel_s;
        end
    end

    // Fetch/decode register; a stalled flush still squashes the held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_dec   <= NOP;
            pc_dec    <= 32'h0000_0000;
            trd_dec   <= 3'd0;
            valid_dec <= 1'b0;
        end else if (!stall_fe) begin
            if (found_s) begin
                ins_dec   <= ins_rdata;
                pc_dec    <= pc_r[sel_s];
                trd_dec   <= sel_s;
                valid_dec <= 1'b1;
            end else begin
                ins_dec   <= NOP;
                valid_dec <= 1'b0;
            end
        end else if (flushID) begin
            ins_dec   <= NOP;
            valid_dec <= 1'b0;
        end
    end

endmodule

// File: tb/tb_insfetch.sv
// Bench for insfetch: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a thread-level reference model.
module tb_insfetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ins_addr;
    logic [31:0] ins_rdata = 32'h0;
    logic        stall_fe = 1'b0;
    logic        jmp_en_exe = 1'b0;
    logic [2:0]  jmp_trd_exe = 3'd0;
    logic [31:0] jmp_pc_exe = 32'h0;
    logic        spawn_en_exe = 1'b0;
    logic [2:0]  spawn_trd_exe = 3'd0;
    logic [31:0] spawn_pc_exe = 32'h0;
    logic        kill_en_exe = 1'b0;
    logic [2:0]  kill_trd_exe = 3'd0;
    logic        init_trd_dec = 1'b0;
    logic [31:0] ins_dec;
    logic [31:0] pc_dec;
    logic [2:0]  trd_dec;
    logic        valid_dec;
    logic        flushID;
    logic [2:0]  new_trd_id;
    logic        no_free_trd;

    insfetch dut (
        .clk(clk), .rst_n(rst_n), .ins_addr(ins_addr), .ins_rdata(ins_rdata),
        .stall_fe(stall_fe),
        .jmp_en_exe(jmp_en_exe), .jmp_trd_exe(jmp_trd_exe), .jmp_pc_exe(jmp_pc_exe),
        .spawn_en_exe(spawn_en_exe), .spawn_trd_exe(spawn_trd_exe), .spawn_pc_exe(spawn_pc_exe),
        .kill_en_exe(kill_en_exe), .kill_trd_exe(kill_trd_exe), .init_trd_dec(init_trd_dec),
        .ins_dec(ins_dec), .pc_dec(pc_dec), .trd_dec(trd_dec), .valid_dec(valid_dec),
        .flushID(flushID), .new_trd_id(new_trd_id), .no_free_trd(no_free_trd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // reference model: thread table plus expected decode register
    logic [31:0] m_pc [8];
    logic [7:0]  m_act, m_res;
    int          m_last;
    logic [31:0] m_ins, m_pcd;
    int          m_trd;
    logic        m_vld;
    // this cycle's predictions
    int          c_sel, c_newid;
    logic        c_found, c_flush, c_nofree;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_pc[i] = 32'h0;
        m_act = 8'h01; m_res = 8'h00; m_last = 7;
        m_ins = 32'h0; m_pcd = 32'h0; m_trd = 0; m_vld = 1'b0;
    endtask

    task automatic idle();
        stall_fe = 1'b0; jmp_en_exe = 1'b0; spawn_en_exe = 1'b0;
        kill_en_exe = 1'b0; init_trd_dec = 1'b0;
        ins_rdata = $urandom;
    endtask

    task automatic check_regs();
        chk("ins_dec", ins_dec, m_ins);
        chk("pc_dec", pc_dec, m_pcd);
        chk("trd_dec", {29'd0, trd_dec}, m_trd);
        chk("valid_dec", {31'd0, valid_dec}, {31'd0, m_vld});
    endtask

    // predict combinational outputs from current inputs and compare
    task automatic settle();
        logic [7:0] elig;
        #1;
        elig = m_act;
        if (jmp_en_exe)  elig[jmp_trd_exe]  = 1'b0;
        if (kill_en_exe) elig[kill_trd_exe] = 1'b0;
        c_found = 1'b0; c_sel = 0;
        for (int k = 1; k <= 8; k++) begin
            int t;
            t = (m_last + k) % 8;
            if (!c_found && elig[t]) begin c_found = 1'b1; c_sel = t; end
        end
        c_flush = m_vld && ((jmp_en_exe && m_trd == jmp_trd_exe) ||
                            (kill_en_exe && m_trd == kill_trd_exe));
        c_nofree = 1'b1; c_newid = 0;
        for (int i = 0; i < 8; i++) begin
            if (c_nofree && !m_act[i] && !m_res[i]) begin c_nofree = 1'b0; c_newid = i; end
        end
        if (c_found) chk("ins_addr", ins_addr, m_pc[c_sel]);
        chk("flushID", {31'd0, flushID}, {31'd0, c_flush});
        chk("new_trd_id", {29'd0, new_trd_id}, c_newid);
        chk("no_free_trd", {31'd0, no_free_trd}, {31'd0, c_nofree});
    endtask

    // advance the model by one clock and compare registered outputs
    task automatic clock_edge();
        logic [31:0] n_pc [8];
        logic [7:0]  n_act, n_res;
        for (int i = 0; i < 8; i++) n_pc[i] = m_pc[i];
        n_act = m_act; n_res = m_res;
        if (!stall_fe && c_found) n_pc[c_sel] = m_pc[c_sel] + 32'd4;
        if (init_trd_dec && !c_nofree) n_res[c_newid] = 1'b1;
        if (jmp_en_exe && !(kill_en_exe && kill_trd_exe == jmp_trd_exe))
            n_pc[jmp_trd_exe] = jmp_pc_exe;
        if (spawn_en_exe && !m_act[spawn_trd_exe] &&
            !(kill_en_exe && kill_trd_exe == spawn_trd_exe)) begin
            n_act[spawn_trd_exe] = 1'b1;
            n_res[spawn_trd_exe] = 1'b0;
            n_pc[spawn_trd_exe]  = spawn_pc_exe;
        end
        if (kill_en_exe) begin
            n_act[kill_trd_exe] = 1'b0;
            n_res[kill_trd_exe] = 1'b0;
        end
        if (!stall_fe) begin
            if (c_found) begin
                m_ins = ins_rdata; m_pcd = m_pc[c_sel]; m_trd = c_sel; m_vld = 1'b1;
                m_last = c_sel;
            end else begin
                m_ins = 32'h0; m_vld = 1'b0;
            end
        end else if (c_flush) begin
            m_ins = 32'h0; m_vld = 1'b0;
        end
        @(posedge clk);
        for (int i = 0; i < 8; i++) m_pc[i] = n_pc[i];
        m_act = n_act; m_res = n_res;
        #1;
        check_regs();
    endtask

    task automatic step();
        settle();
        clock_edge();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        do_reset();

        // three idle cycles: thread 0 walks 0, 4, 8
        settle(); chk("lit_addr0", ins_addr, 32'h0); clock_edge();
        chk("lit_v0", {31'd0, valid_dec}, 32'd1); chk("lit_pc0", pc_dec, 32'h0);
        idle(); step(); chk("lit_pc4", pc_dec, 32'h4); chk("lit_trd4", {29'd0, trd_dec}, 32'd0);
        idle(); step(); chk("lit_pc8", pc_dec, 32'h8);

        // spawn thread 1 at 0x100 and check interleaving
        idle(); spawn_en_exe = 1'b1; spawn_trd_exe = 3'd1; spawn_pc_exe = 32'h100;
        step(); chk("lit_sp_pc", pc_dec, 32'hC);
        idle(); step(); chk("lit_t1a", {pc_dec[31:3], trd_dec}, {29'h20, 3'd1});
        idle(); step(); chk("lit_t0b", {pc_dec[31:3], trd_dec}, {29'h2, 3'd0});
        idle(); step(); chk("lit_t1b", pc_dec, 32'h104);

        // redirect thread 1 while it sits in decode
        idle(); jmp_en_exe = 1'b1; jmp_trd_exe = 3'd1; jmp_pc_exe = 32'h200;
        settle(); chk("lit_flush", {31'd0, flushID}, 32'd1); clock_edge();
        chk("lit_jt0", pc_dec, 32'h14);
        idle(); step(); chk("lit_jt1", pc_dec, 32'h200);

        // two-cycle stall with a redirect of thread 0 during it
        idle(); stall_fe = 1'b1; jmp_en_exe = 1'b1; jmp_trd_exe = 3'd0; jmp_pc_exe = 32'h300;
        step(); chk("lit_st_pc", pc_dec, 32'h200);
        idle(); stall_fe = 1'b1; step(); chk("lit_st_trd", {29'd0, trd_dec}, 32'd1);
        idle(); step(); chk("lit_post_st", pc_dec, 32'h300);

        // reset mid-run, then fill all free IDs by reservation
        do_reset();
        idle(); step(); chk("lit_rst_pc", pc_dec, 32'h0);
        for (int i = 1; i <= 7; i++) begin
            idle(); init_trd_dec = 1'b1;
            settle(); chk("lit_newid", {29'd0, new_trd_id}, i); clock_edge();
        end
        idle(); settle();
        chk("lit_nofree", {31'd0, no_free_trd}, 32'd1);
        chk("lit_newid0", {29'd0, new_trd_id}, 32'd0);
        clock_edge();

        // kill plus redirect of the only live thread: bubbles follow
        idle(); kill_en_exe = 1'b1; kill_trd_exe = 3'd0;
        jmp_en_exe = 1'b1; jmp_trd_exe = 3'd0; jmp_pc_exe = 32'h400;
        step(); chk("lit_kill_v", {31'd0, valid_dec}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            idle(); step(); chk("lit_bubble", {ins_dec[31:1], valid_dec}, 32'd0);
        end

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ins_rdata     = $urandom;
            stall_fe      = ($urandom_range(0, 99) < 20);
            jmp_en_exe    = ($urandom_range(0, 99) < 15);
            jmp_trd_exe   = 3'($urandom_range(0, 7));
            jmp_pc_exe    = {$urandom_range(0, 32'hFFFF), 2'b00} + 32'hFFFF_0000;
            spawn_en_exe  = ($urandom_range(0, 99) < 20);
            spawn_trd_exe = 3'($urandom_range(0, 7));
            spawn_pc_exe  = {$urandom_range(0, 32'hFFFF), 2'b00};
            kill_en_exe   = ($urandom_range(0, 99) < 10);
            kill_trd_exe  = 3'($urandom_range(0, 7));
            init_trd_dec  = ($urandom_range(0, 99) < 20);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
